// File: rtl/pipe_fetch_ctrl.sv
// IF-stage PC sequencer: req/ack imem fetch into a one-entry output register.
// Define PIPE_DELAY_SLOT_EN to keep the branch-delay-slot instruction on redirect.
module pipe_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_ins,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  input  logic        if_ready
);

  logic [31:0] pc;
  logic [31:0] tgt;
  logic [31:0] pc4;
  logic [31:0] target;
  logic        busy;
  logic        kill;
  logic        redir;
  logic        slot_free;
  logic        acc;
  logic        live_ack;
  logic        xfer;
  logic        pend;
  logic        redirect;
  logic        keep_out;
  logic        keep_mem;
  logic        load;

  assign slot_free = !if_valid | if_ready;
  assign imem_req  = !reset & (busy | slot_free);
  assign imem_addr = pc;
  assign pc4       = pc + 32'd4;
  assign acc       = imem_req & imem_ack;
  assign live_ack  = acc & !kill;
  assign xfer      = if_valid & if_ready;
  assign pend      = imem_req & !imem_ack;
  assign redirect  = |pcsource;

  always_comb begin
    target = pc4;
    unique case (1'b1)
      pcsource == 2'b01: target = bpc;
      pcsource == 2'b10: target = rpc;
      pcsource == 2'b11: target = jpc;
      default:           target = pc4;
    endcase
  end

`ifdef PIPE_DELAY_SLOT_EN
  // oldest squashed entry survives: held output first, else the memory one
  assign keep_out = redirect & if_valid & !if_ready;
  assign keep_mem = redirect & !if_valid;
`else
  assign keep_out = 1'b0;
  assign keep_mem = 1'b0;
`endif

  assign load = live_ack & (!redirect | keep_mem);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      tgt      <= '0;
      redir    <= 1'b0;
      busy     <= 1'b0;
      kill     <= 1'b0;
      if_valid <= 1'b0;
      if_ins   <= '0;
      if_pc    <= '0;
      if_pc4   <= '0;
    end else begin
      busy <= pend;
      if (load) begin
        if_valid <= 1'b1;
        if_ins   <= imem_rdata;
        if_pc    <= pc;
        if_pc4   <= pc4;
      end else if (xfer | (redirect & !keep_out)) begin
        if_valid <= 1'b0;
      end
      if (acc)
        kill <= 1'b0;
      if (redirect & pend & !keep_mem)
        kill <= 1'b1;
      // an outstanding request keeps its address until acked
      if (redirect) begin
        if (pend) begin
          tgt   <= target;
          redir <= 1'b1;
        end else begin
          pc    <= target;
          redir <= 1'b0;
        end
      end else if (acc) begin
        pc    <= redir ? tgt : pc4;
        redir <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// Directed bench for pipe_fetch_ctrl with a wait-state imem responder.
// Redirect expectations follow PIPE_DELAY_SLOT_EN when defined.
module tb_pipe_fetch_ctrl;

  logic        clock;
  logic        reset;
  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] rpc;
  logic [31:0] jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_ins;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        if_ready;

  logic        ack_force;
  int unsigned wait_n;
  int unsigned cnt;
  int          errors;
  int          checks;

  pipe_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clock      (clock),
    .reset      (reset),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_ins     (if_ins),
    .if_pc      (if_pc),
    .if_pc4     (if_pc4),
    .if_ready   (if_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // memory acks after wait_n extra cycles of a held request
  assign imem_ack   = ack_force | (imem_req & (cnt == wait_n));
  assign imem_rdata = imem_addr + 32'h1000_0000;

  always @(posedge clock or posedge reset) begin
    if (reset)
      cnt <= 0;
    else if (imem_req && !imem_ack)
      cnt <= cnt + 1;
    else
      cnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clock);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    reset     = 1'b1;
    pcsource  = 2'b00;
    bpc       = '0;
    rpc       = '0;
    jpc       = '0;
    if_ready  = 1'b1;
    wait_n    = 0;
    ack_force = 1'b0;

    // reset state, with a stray ack while held in reset
    tick();
    tick();
    ack_force = 1'b1;
    #1;
    chkb("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chkb("rst_valid", if_valid, 1'b0);
    chk("rst_ins", if_ins, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_pc4", if_pc4, 32'h0);
    tick();
    chkb("rst_stray", if_valid, 1'b0);
    ack_force = 1'b0;
    reset = 1'b0;
    #1;
    chkb("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);

    // zero-wait streaming
    tick();
    chkb("zw_valid0", if_valid, 1'b1);
    chk("zw_pc0", if_pc, 32'h0);
    chk("zw_ins0", if_ins, 32'h1000_0000);
    chk("zw_addr4", imem_addr, 32'h4);
    tick();
    chk("zw_pc4", if_pc, 32'h4);
    chk("zw_addr8", imem_addr, 32'h8);
    tick();
    chk("zw_pc8", if_pc, 32'h8);
    chk("zw_pc8_4", if_pc4, 32'hC);
    chk("zw_addrC", imem_addr, 32'hC);

    // three wait cycles: one instruction per four cycles
    wait_n = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ws_addr_hold", imem_addr, 32'hC);
      chkb("ws_valid0", if_valid, 1'b0);
    end
    tick();
    chkb("ws_valid1", if_valid, 1'b1);
    chk("ws_pc", if_pc, 32'hC);
    chk("ws_pc4", if_pc4, 32'h10);
    chk("ws_addr", imem_addr, 32'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chkb("ws_gap", if_valid, 1'b0);
    end
    tick();
    chk("ws_pc2", if_pc, 32'h10);
    chk("ws_pc4_2", if_pc4, 32'h14);
    chk("ws_ins2", if_ins, 32'h1000_0010);

    // stall with a zero-wait ack on entry
    wait_n = 0;
    tick();
    chk("st_entry_pc", if_pc, 32'h14);
    if_ready = 1'b0;
    #1;
    chkb("st_req_drop", imem_req, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_pc", if_pc, 32'h14);
      chk("st_ins", if_ins, 32'h1000_0014);
      chkb("st_req", imem_req, 1'b0);
      chkb("st_valid", if_valid, 1'b1);
    end
    if_ready = 1'b1;
    #1;
    chkb("st_rel_req", imem_req, 1'b1);
    chk("st_rel_addr", imem_addr, 32'h18);
    tick();
    chk("st_next", if_pc, 32'h18);
    tick();
    chk("st_next2", if_pc, 32'h1C);
    chk("st_addr20", imem_addr, 32'h20);

    // jump while the 0x20 fetch is in flight
    wait_n = 2;
    tick();
    chk("rd_inflight", imem_addr, 32'h20);
    chkb("rd_valid0", if_valid, 1'b0);
    pcsource = 2'b11;
    jpc = 32'h100;
    tick();
    pcsource = 2'b00;
    chk("rd_addr_hold", imem_addr, 32'h20);
    tick();
    chk("rd_addr_tgt", imem_addr, 32'h100);
`ifdef PIPE_DELAY_SLOT_EN
    chkb("rd_slot_valid", if_valid, 1'b1);
    chk("rd_slot_pc", if_pc, 32'h20);
    chk("rd_slot_ins", if_ins, 32'h1000_0020);
`else
    chkb("rd_drop_valid", if_valid, 1'b0);
`endif
    for (int i = 0; i < 2; i++) begin
      tick();
      chkb("rd_gap", if_valid, 1'b0);
    end
    tick();
    chkb("rd_tgt_valid", if_valid, 1'b1);
    chk("rd_tgt_pc", if_pc, 32'h100);
    chk("rd_tgt_ins", if_ins, 32'h1000_0100);

    // branch to the top of memory, acked on the redirect edge; pc+4 wraps
    wait_n = 0;
    pcsource = 2'b01;
    bpc = 32'hFFFF_FFFC;
    tick();
    pcsource = 2'b00;
    chkb("wr_squash", if_valid, 1'b0);
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_pc", if_pc, 32'hFFFF_FFFC);
    chk("wr_pc4", if_pc4, 32'h0);
    chk("wr_addr0", imem_addr, 32'h0);
    tick();
    chk("wr_pc0", if_pc, 32'h0);

    // reset in the middle of a waited request
    wait_n = 3;
    reset = 1'b1;
    ack_force = 1'b1;
    #1;
    chkb("mr_req", imem_req, 1'b0);
    chkb("mr_valid", if_valid, 1'b0);
    chk("mr_addr", imem_addr, 32'h0);
    chk("mr_pc", if_pc, 32'h0);
    tick();
    chkb("mr_stray", if_valid, 1'b0);
    ack_force = 1'b0;
    wait_n = 0;
    reset = 1'b0;
    #1;
    chkb("mr_restart_req", imem_req, 1'b1);
    chk("mr_restart_addr", imem_addr, 32'h0);
    tick();
    chkb("mr_valid1", if_valid, 1'b1);
    chk("mr_pc0", if_pc, 32'h0);
    chk("mr_ins0", if_ins, 32'h1000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
